fetch_stage: RTL

Instruction fetch stage of the RISC-V pipeline. It sits directly upstream of the first 32-bit pipeline register, holds the program counter, and issues word requests to instruction memory. It buffers returned instructions with their PC and presents them downstream on a valid/ready handshake. Branch/jump redirects flush buffered and in-flight fetches.

---
 rtl/rv_fetch_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_stage.sv | 103 ++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RISC-V instruction fetch stage.
// Imported by the fetch FIFO, the fetch stage top and its bench.
package rv_fetch_pkg;

  localparam int INSN_BYTES = 4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    RESET_WAIT,
    RUN,
    KILL
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bus.
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Output buffer of fetched {pc, instr} entries.
// Head is read straight from storage so outputs stay registered.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  wdata,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  function automatic logic [AW-1:0] bump(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem issue, kill tracking.
// Fetched words are buffered in fetch_fifo for the IF/ID register.
module fetch_stage
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4,
  localparam int         CW       = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          CE,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  fetch_stage_if.master imem,
  output logic          valid_out,
  input  logic          ready_in,
  output logic [31:0]   instr_out,
  output logic [31:0]   pc_out
);

  fetch_state_e  state;
  fetch_state_e  state_nxt;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic          req_valid;
  logic          accept;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  fetch_entry_t  wdata;
  fetch_entry_t  head;
  logic          unused_bits;

  // Space is reserved for the in-flight word, so a push never hits a full FIFO.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    unique case (state)
      RESET_WAIT: state_nxt = RUN;
      RUN, KILL: begin
        state_nxt = (redirect_valid && inflight) ? KILL : RUN;
      end
      default: state_nxt = RESET_WAIT;
    endcase
    if (state != RESET_WAIT && CE && !redirect_valid &&
        occupancy < (CW + 1)'(DEPTH)) begin
      req_valid = 1'b1;
    end
  end

  assign accept = req_valid && imem.imem_req_ready;
  assign push   = imem.imem_rsp_valid && inflight && !redirect_valid;
  assign pop    = valid_out && ready_in;
  assign wdata  = '{pc: req_pc, instr: imem.imem_rsp_data};

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_addr      = pc;

  assign valid_out = (count != '0);
  assign instr_out = head.instr;
  assign pc_out    = head.pc;

  assign unused_bits = ^redirect_pc[1:0];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= RESET_WAIT;
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= accept;
      if (accept) begin
        req_pc <= pc;
      end
      if (redirect_valid) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (accept) begin
        pc <= pc + 32'(INSN_BYTES);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst_n(RSTn),
    .flush(redirect_valid),
    .push (push),
    .wdata(wdata),
    .pop  (pop),
    .head (head),
    .count(count)
  );

endmodule
